// File: rtl/encoder_8to3_df_pkg.sv
// Shared widths, reset values and the packed result type for the 8-to-3 encoder.
// The 5-bit result struct is what the top-level output register holds.
package encoder_8to3_df_pkg;

  localparam int ENC_IN_W  = 8;
  localparam int ENC_OUT_W = 3;

  localparam logic [ENC_OUT_W-1:0] ENC_RST_OUT = 3'b000;

  typedef struct packed {
    logic [ENC_OUT_W-1:0] idx;
    logic                 valid;
    logic                 multi;
  } enc_res_t;

  localparam enc_res_t ENC_RST_RES = '{idx: ENC_RST_OUT, valid: 1'b0, multi: 1'b0};

endpackage

// File: rtl/encoder_8to3_core.sv
// Combinational 8-to-3 encode: one-hot OR-plane plus a highest-index priority fallback.
// Zero input yields index 0 with valid low; no state, no handshake.
module encoder_8to3_core
  import encoder_8to3_df_pkg::*;
(
  input  logic [ENC_IN_W-1:0]  in_i,
  output logic [ENC_OUT_W-1:0] out_c_o,
  output logic                 valid_c_o,
  output logic                 multi_c_o
);

  logic [ENC_OUT_W-1:0] oh_idx;
  logic [ENC_OUT_W-1:0] pri_idx;
  logic                 multi;

  // Exact only when at most one bit is set.
  assign oh_idx[2] = |in_i[7:4];
  assign oh_idx[1] = |{in_i[7:6], in_i[3:2]};
  assign oh_idx[0] = |{in_i[7], in_i[5], in_i[3], in_i[1]};

  always_comb begin
    pri_idx = ENC_RST_OUT;
    for (int k = 0; k < ENC_IN_W; k++) begin
      if (in_i[k]) pri_idx = ENC_OUT_W'(k);
    end
  end

  always_comb begin
    multi = 1'b0;
    for (int i = 0; i < ENC_IN_W - 1; i++) begin
      for (int j = i + 1; j < ENC_IN_W; j++) begin
        multi = multi | (in_i[i] & in_i[j]);
      end
    end
  end

  assign out_c_o   = multi ? pri_idx : oh_idx;
  assign valid_c_o = |in_i;
  assign multi_c_o = multi;

endmodule

// File: rtl/encoder_8to3_df.sv
// 8-to-3 encoder with a single registered output stage (one-cycle latency).
// Accepts a new sample every cycle; synchronous reset overrides the sample.
module encoder_8to3_df
  import encoder_8to3_df_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ENC_IN_W-1:0]  in,
  output logic [ENC_OUT_W-1:0] out,
  output logic                 valid,
  output logic                 multi
);

  enc_res_t res_d;
  enc_res_t res_q;

  encoder_8to3_core u_core (
    .in_i      (in),
    .out_c_o   (res_d.idx),
    .valid_c_o (res_d.valid),
    .multi_c_o (res_d.multi)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= ENC_RST_RES;
    end else begin
      res_q <= res_d;
    end
  end

  assign out   = res_q.idx;
  assign valid = res_q.valid;
  assign multi = res_q.multi;

endmodule

// File: tb/tb_encoder_8to3_df.sv
// Directed plus random/exhaustive checks of encoder_8to3_df against a behavioural model.
// Outputs are compared #1 after each rising edge and held-value checked at the falling edge.
module tb_encoder_8to3_df;

  logic       clk = 1'b0;
  logic       rst_s;
  logic [7:0] in_s;
  logic [2:0] out_w;
  logic       valid_w;
  logic       multi_w;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q;

  encoder_8to3_df dut (
    .clk   (clk),
    .rst   (rst_s),
    .in    (in_s),
    .out   (out_w),
    .valid (valid_w),
    .multi (multi_w)
  );

  always #5 clk = ~clk;

  // Reference: index of highest set bit, set count decides valid/multi.
  function automatic logic [4:0] ref_model(input logic [7:0] v);
    int hi;
    int cnt;
    hi  = 0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) begin
        hi  = k;
        cnt = cnt + 1;
      end
    end
    return {hi[2:0], (cnt >= 1), (cnt >= 2)};
  endfunction

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed out/valid/multi=%b_%b_%b expected=%b_%b_%b",
             tag, obs[4:2], obs[1], obs[0], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic [7:0] v, input logic r, input string tag);
    in_s  = v;
    rst_s = r;
    @(negedge clk);
    chk({tag, "_hold"}, {out_w, valid_w, multi_w}, exp_q);
    @(posedge clk);
    #1;
    exp_q = r ? 5'b0 : ref_model(v);
    chk(tag, {out_w, valid_w, multi_w}, exp_q);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] v;

    rst_s = 1'b1;
    in_s  = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    exp_q = 5'b0;
    chk("reset", {out_w, valid_w, multi_w}, 5'b000_0_0);

    for (int k = 0; k < 8; k++) begin
      v = 8'h01 << k;
      step(v, 1'b0, $sformatf("onehot_%0d", k));
      chk($sformatf("onehot_const_%0d", k), {out_w, valid_w, multi_w},
          {k[2:0], 1'b1, 1'b0});
    end

    step(8'h00, 1'b0, "zero");
    chk("zero_const", {out_w, valid_w, multi_w}, 5'b000_0_0);
    step(8'h05, 1'b0, "multi_05");
    chk("multi_05_const", {out_w, valid_w, multi_w}, 5'b010_1_1);
    step(8'hFF, 1'b0, "multi_ff");
    chk("multi_ff_const", {out_w, valid_w, multi_w}, 5'b111_1_1);
    step(8'h81, 1'b0, "multi_81");
    chk("multi_81_const", {out_w, valid_w, multi_w}, 5'b111_1_1);

    step(8'h40, 1'b0, "mid_pre");
    step(8'h40, 1'b1, "mid_rst");
    chk("mid_rst_const", {out_w, valid_w, multi_w}, 5'b000_0_0);
    step(8'h08, 1'b0, "mid_release");
    chk("mid_release_const", {out_w, valid_w, multi_w}, 5'b011_1_0);

    for (int n = 0; n < 256; n++) begin
      v = n[7:0];
      step(v, 1'b0, $sformatf("exh_%02h", v));
    end

    for (int n = 0; n < 200; n++) begin
      v = 8'($urandom);
      step(v, ($urandom_range(0, 15) == 0), $sformatf("rnd_%0d_%02h", n, v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
